// File: rtl/alu_cmd_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the ALU command sequencer.
// Optional build macro ALU_OP_CHECK_EN is consumed by alu_cmd_seq.
package alu_cmd_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;
  localparam int OP_W       = 5;

  localparam logic [OP_W-1:0] OP_NOP = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB = 5'd2;
  localparam logic [OP_W-1:0] OP_AND = 5'd3;
  localparam logic [OP_W-1:0] OP_OR  = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR = 5'd5;
  localparam logic [OP_W-1:0] OP_NOR = 5'd6;
  localparam logic [OP_W-1:0] OP_MAX = OP_NOR;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  function automatic logic isIllegalOp(input logic [OP_W-1:0] op);
    return (op > OP_MAX);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports, one synchronous write port
// and an asynchronous active-low clear of every entry.
module regfile_2r1w
  import alu_cmd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_raddrA,
  input  logic [ADDR_W-1:0] i_raddrB,
  output logic [DATA_W-1:0] o_rdataA,
  output logic [DATA_W-1:0] o_rdataB,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdataA = r_mem[i_raddrA];
  assign o_rdataB = r_mem[i_raddrB];

endmodule

// File: rtl/alu_cmd_seq.sv
// Command-driven initiator for the external combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_OP_CHECK_EN to turn opcodes above OP_MAX into flagged no-op responses.
module alu_cmd_seq
  import alu_cmd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_rd,
  output logic              rsp_err
);

  state_t            r_state;
  state_t            w_nextState;
  logic              w_cmdReady;
  logic              w_rspValid;
  logic              w_accept;
  logic              w_we;
  logic              w_illegal;
  logic [DATA_W-1:0] w_rdataA;
  logic [DATA_W-1:0] w_rdataB;

  logic [DATA_W-1:0] r_aluA;
  logic [DATA_W-1:0] r_aluB;
  logic [OP_W-1:0]   r_aluOp;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_res;
  logic              r_err;

`ifdef ALU_OP_CHECK_EN
  assign w_illegal = isIllegalOp(cmd_op);
`else
  assign w_illegal = 1'b0;
`endif

  // Operands are read combinationally at accept, so rs==rd sees the old value.
  regfile_2r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raddrA(cmd_rs1),
    .i_raddrB(cmd_rs2),
    .o_rdataA(w_rdataA),
    .o_rdataB(w_rdataB),
    .i_we    (w_we),
    .i_waddr (r_rd),
    .i_wdata (alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_cmdReady  = 1'b0;
    w_rspValid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmdReady = 1'b1;
        if (cmd_valid) begin
          w_nextState = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_nextState = ST_RESP;
      end
      ST_RESP: begin
        w_rspValid = 1'b1;
        if (rsp_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign w_accept = cmd_valid & w_cmdReady;
  // Illegal opcodes are demoted to NOP at accept, so one NOP test covers both cases.
  assign w_we     = (r_state == ST_EXEC) && (r_aluOp != OP_NOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aluA  <= '0;
      r_aluB  <= '0;
      r_aluOp <= OP_NOP;
      r_rd    <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_aluA  <= w_rdataA;
        r_aluB  <= cmd_use_imm ? cmd_imm : w_rdataB;
        r_aluOp <= w_illegal ? OP_NOP : cmd_op;
        r_rd    <= cmd_rd;
        r_err   <= w_illegal;
      end
      if (r_state == ST_EXEC) begin
        r_res   <= (r_aluOp == OP_NOP) ? '0 : alu_out;
        r_aluOp <= OP_NOP;
      end
    end
  end

  assign cmd_ready = w_cmdReady;
  assign rsp_valid = w_rspValid;
  assign alu_a     = r_aluA;
  assign alu_b     = r_aluB;
  assign alu_op    = r_aluOp;
  assign rsp_data  = r_res;
  assign rsp_rd    = r_rd;
  assign rsp_err   = r_err;

endmodule
